// File: rtl/dht11_pkg.sv
// Shared types and constants for the DHT11 poll scheduler: FSM encoding, the
// minimum request gap, the millisecond counter width and a threshold helper.
package dht11_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        BUSY    = 2'd2,
        BACKOFF = 2'd3
    } state_t;

    localparam int MIN_GAP_MS = 1000;
    localparam int MS_W       = 16;

    // True when the count has reached the target, counting the tick that arrives this cycle.
    function automatic logic reached(input logic [MS_W-1:0] cnt,
                                     input logic [MS_W-1:0] target,
                                     input logic            tick);
        logic [MS_W:0] next_cnt;
        next_cnt = {1'b0, cnt} + {{MS_W{1'b0}}, tick};
        return next_cnt >= {1'b0, target};
    endfunction

endpackage

// File: rtl/dht11_ms_tick.sv
// Free-running 1 ms strobe derived from CLK_HZ; with CLK_HZ below 2000 the
// divider degenerates to a strobe on every cycle.
module dht11_ms_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || tick) cnt <= '0;
        else               cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/dht11_poll_scheduler.sv
// Sequences DHT11 measurements: power-up wait, periodic/triggered requests, timeout and
// bounded retry, last-good data hold. Define DHT11_AVG_EN for a 4-sample running mean.
module dht11_poll_scheduler
    import dht11_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int POWERUP_MS   = 1000,
    parameter int PERIOD_MS    = 2000,
    parameter int TIMEOUT_MS   = 50,
    parameter int RETRY_GAP_MS = 1000,
    parameter int MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_trigger,
    output logic       o_start,
    input  logic       i_done,
    input  logic       i_valid,
    input  logic [7:0] i_humidity,
    input  logic [7:0] i_temperature,
    output logic [7:0] humidity,
    output logic [7:0] current_temperature,
    output logic       o_data_valid,
    output logic       o_update,
    output logic       o_fault,
    output logic       o_busy
);

    localparam logic [MS_W-1:0] POWERUP_T = MS_W'(POWERUP_MS);
    localparam logic [MS_W-1:0] PERIOD_T  = MS_W'(PERIOD_MS);
    localparam logic [MS_W-1:0] TIMEOUT_T = MS_W'(TIMEOUT_MS);
    localparam logic [MS_W-1:0] GAP_T     = MS_W'(RETRY_GAP_MS);
    localparam logic [MS_W-1:0] MIN_GAP_T = MS_W'(MIN_GAP_MS);
    localparam logic [7:0]      MAX_R     = 8'(MAX_RETRY);

    // Handshake: o_start is a one-cycle request with no ready; the controller answers with a
    // one-cycle i_done, and i_valid/i_humidity/i_temperature are meaningful only in that cycle.

    logic            tick;
    state_t          state, state_next;
    logic [MS_W-1:0] ms_cnt, wait_cnt;
    logic            powerup, trig_pend;
    logic [7:0]      retry_cnt;
    logic            attempt_ok, attempt_fail, can_retry;

    dht11_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign can_retry = (retry_cnt < MAX_R);
    assign o_start   = (state == START);
    assign o_busy    = (state != IDLE);

    always_comb begin
        state_next   = state;
        attempt_ok   = 1'b0;
        attempt_fail = 1'b0;
        case (state)
            IDLE: begin
                if (reached(ms_cnt, powerup ? POWERUP_T : PERIOD_T, tick))
                    state_next = START;
                else if (!powerup && (i_trigger || trig_pend) && reached(ms_cnt, MIN_GAP_T, tick))
                    state_next = START;
            end
            START: state_next = BUSY;
            BUSY: begin
                // A done arriving in the timeout cycle still counts as a response.
                if (i_done) begin
                    attempt_ok   = i_valid;
                    attempt_fail = !i_valid;
                end else if (reached(wait_cnt, TIMEOUT_T, tick)) begin
                    attempt_fail = 1'b1;
                end
                if (attempt_ok)        state_next = IDLE;
                else if (attempt_fail) state_next = can_retry ? BACKOFF : IDLE;
            end
            BACKOFF: begin
                if (reached(wait_cnt, GAP_T, tick)) state_next = START;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ms_cnt       <= '0;
            wait_cnt     <= '0;
            powerup      <= 1'b1;
            trig_pend    <= 1'b0;
            retry_cnt    <= '0;
            o_data_valid <= 1'b0;
            o_update     <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            state    <= state_next;
            o_update <= attempt_ok;

            // The request period runs from the START cycle, including its tick.
            if (state == START)              ms_cnt <= MS_W'(tick);
            else if (tick && ms_cnt != '1)   ms_cnt <= ms_cnt + MS_W'(1);

            // The retry gap is measured from the cycle the attempt failed.
            if (state == START)              wait_cnt <= '0;
            else if (attempt_fail)           wait_cnt <= MS_W'(tick);
            else if (tick && wait_cnt != '1) wait_cnt <= wait_cnt + MS_W'(1);

            if (state == START) powerup <= 1'b0;

            if (state == START)                  trig_pend <= 1'b0;
            else if (state == IDLE && i_trigger) trig_pend <= 1'b1;

            if (attempt_ok) begin
                retry_cnt    <= '0;
                o_data_valid <= 1'b1;
                o_fault      <= 1'b0;
            end else if (attempt_fail) begin
                if (can_retry) begin
                    retry_cnt <= retry_cnt + 8'd1;
                end else begin
                    retry_cnt <= '0;
                    o_fault   <= 1'b1;
                end
            end
        end
    end

`ifdef DHT11_AVG_EN
    logic [7:0] h_slot [4];
    logic [7:0] t_slot [4];
    logic [9:0] h_sum, t_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_slot <= '{default: '0};
            t_slot <= '{default: '0};
            h_sum  <= '0;
            t_sum  <= '0;
        end else if (attempt_ok) begin
            if (!o_data_valid) begin
                h_slot <= '{default: i_humidity};
                t_slot <= '{default: i_temperature};
                h_sum  <= {i_humidity, 2'b00};
                t_sum  <= {i_temperature, 2'b00};
            end else begin
                h_slot <= '{i_humidity, h_slot[0], h_slot[1], h_slot[2]};
                t_slot <= '{i_temperature, t_slot[0], t_slot[1], t_slot[2]};
                h_sum  <= h_sum - {2'b00, h_slot[3]} + {2'b00, i_humidity};
                t_sum  <= t_sum - {2'b00, t_slot[3]} + {2'b00, i_temperature};
            end
        end
    end

    assign humidity            = h_sum[9:2];
    assign current_temperature = t_sum[9:2];
`else
    logic [7:0] h_q, t_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q <= '0;
            t_q <= '0;
        end else if (attempt_ok) begin
            h_q <= i_humidity;
            t_q <= i_temperature;
        end
    end

    assign humidity            = h_q;
    assign current_temperature = t_q;
`endif

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Bench for dht11_poll_scheduler: a scripted sensor table on a 20 ms-period instance and
// trigger sequences on a 2000 ms-period instance, with a scoreboard on o_update.
module tb_dht11_poll_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, i_trigger, i_done, i_valid;
  logic [7:0] i_humidity, i_temperature;
  logic       o_start, o_data_valid, o_update, o_fault, o_busy;
  logic [7:0] humidity, current_temperature;

  logic       reset_b, i_trigger_b, i_done_b, i_valid_b;
  logic [7:0] i_humidity_b, i_temperature_b;
  logic       o_start_b, o_data_valid_b, o_update_b, o_fault_b, o_busy_b;
  logic [7:0] humidity_b, current_temperature_b;

  dht11_poll_scheduler #(
    .CLK_HZ(1000), .POWERUP_MS(10), .PERIOD_MS(20), .TIMEOUT_MS(5),
    .RETRY_GAP_MS(3), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .reset(reset), .i_trigger(i_trigger), .o_start(o_start),
    .i_done(i_done), .i_valid(i_valid), .i_humidity(i_humidity),
    .i_temperature(i_temperature), .humidity(humidity),
    .current_temperature(current_temperature), .o_data_valid(o_data_valid),
    .o_update(o_update), .o_fault(o_fault), .o_busy(o_busy)
  );

  dht11_poll_scheduler #(
    .CLK_HZ(1000), .POWERUP_MS(10), .PERIOD_MS(2000), .TIMEOUT_MS(5),
    .RETRY_GAP_MS(3), .MAX_RETRY(2)
  ) dut_b (
    .clk(clk), .reset(reset_b), .i_trigger(i_trigger_b), .o_start(o_start_b),
    .i_done(i_done_b), .i_valid(i_valid_b), .i_humidity(i_humidity_b),
    .i_temperature(i_temperature_b), .humidity(humidity_b),
    .current_temperature(current_temperature_b), .o_data_valid(o_data_valid_b),
    .o_update(o_update_b), .o_fault(o_fault_b), .o_busy(o_busy_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit         silent;
    bit         valid;
    logic [7:0] h;
    logic [7:0] t;
    logic [7:0] eh;
    logic [7:0] et;
    int         gap;
    bit         fault;
  } vec_t;

  vec_t vec [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_near(input string name, input int act, input int exp);
    n_checks++;
    if (act < exp - 1 || act > exp + 1) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d +/-1 (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_start(input bit sel_b, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel_b ? o_start_b : o_start) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_timeout: no o_start within %0d cycles (cycle %0d)", budget, cyc);
      t = cyc;
    end
  endtask

  // Scoreboard: every o_update must match the oldest outstanding good sample.
  always @(negedge clk) begin
    if (o_update === 1'b1) begin : pop_blk
      logic [15:0] e;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL update_unexpected: o_update=1 with nothing outstanding, h=%0d t=%0d (cycle %0d)",
                 humidity, current_temperature, cyc);
      end else begin
        e = exp_q.pop_front();
        check("upd_humidity", 32'(humidity), 32'(e[15:8]));
        check("upd_temperature", 32'(current_temperature), 32'(e[7:0]));
      end
    end
  end

  initial begin
    int t, t_prev;
    logic [7:0] last_h, last_t;

    vec[0] = '{0, 1, 8'd45, 8'd20, 8'd45, 8'd20, 10, 0};
    vec[2] = '{0, 0, 8'd99, 8'd99, 8'd0,  8'd0,  20, 0};
    vec[3] = '{0, 0, 8'd98, 8'd98, 8'd0,  8'd0,  5,  0};
    vec[5] = '{1, 0, 8'd0,  8'd0,  8'd0,  8'd0,  20, 0};
    vec[6] = '{1, 0, 8'd0,  8'd0,  8'd0,  8'd0,  8,  0};
    vec[7] = '{1, 0, 8'd0,  8'd0,  8'd0,  8'd0,  8,  1};
`ifdef DHT11_AVG_EN
    vec[1] = '{0, 1, 8'd45, 8'd24, 8'd45, 8'd21, 20, 0};
    vec[4] = '{0, 1, 8'd50, 8'd28, 8'd46, 8'd23, 5,  0};
    vec[8] = '{0, 1, 8'd60, 8'd32, 8'd50, 8'd26, 20, 0};
`else
    vec[1] = '{0, 1, 8'd45, 8'd24, 8'd45, 8'd24, 20, 0};
    vec[4] = '{0, 1, 8'd50, 8'd28, 8'd50, 8'd28, 5,  0};
    vec[8] = '{0, 1, 8'd60, 8'd32, 8'd60, 8'd32, 20, 0};
`endif

    reset = 1'b1; i_trigger = 1'b0; i_done = 1'b0; i_valid = 1'b0;
    i_humidity = '0; i_temperature = '0;
    reset_b = 1'b1; i_trigger_b = 1'b0; i_done_b = 1'b0; i_valid_b = 1'b0;
    i_humidity_b = '0; i_temperature_b = '0;
    last_h = '0; last_t = '0;

    repeat (3) @(negedge clk);
    check("rst_start", 32'(o_start), 0);
    check("rst_humidity", 32'(humidity), 0);
    check("rst_temperature", 32'(current_temperature), 0);
    check("rst_data_valid", 32'(o_data_valid), 0);
    check("rst_update", 32'(o_update), 0);
    check("rst_fault", 32'(o_fault), 0);
    check("rst_busy", 32'(o_busy), 0);

    reset = 1'b0;
    t_prev = cyc;

    // Sensor table: good samples, invalid-then-good retries, silent retries to fault, recovery.
    for (int i = 0; i < 9; i++) begin
      wait_start(1'b0, 40, t);
      check_near($sformatf("gap_%0d", i), t - t_prev, vec[i].gap);
      t_prev = t;
      @(negedge clk);
      check($sformatf("start_pulse_%0d", i), 32'(o_start), 0);
      if (!vec[i].silent) begin
        @(negedge clk);
        i_done = 1'b1; i_valid = vec[i].valid;
        i_humidity = vec[i].h; i_temperature = vec[i].t;
        if (vec[i].valid) begin
          exp_q.push_back({vec[i].eh, vec[i].et});
          last_h = vec[i].eh;
          last_t = vec[i].et;
        end
        @(negedge clk);
        i_done = 1'b0; i_valid = 1'b0;
        @(negedge clk);
      end else begin
        repeat (5) @(negedge clk);
      end
      check($sformatf("fault_%0d", i), 32'(o_fault), 32'(vec[i].fault));
      check($sformatf("data_valid_%0d", i), 32'(o_data_valid), 1);
      if (vec[i].fault) begin
        check("fault_busy", 32'(o_busy), 0);
        check("fault_held_h", 32'(humidity), 32'(last_h));
        check("fault_held_t", 32'(current_temperature), 32'(last_t));
      end
    end

    // Reset one cycle after a request; a late done must be ignored.
    wait_start(1'b0, 40, t);
    check_near("gap_before_reset", t - t_prev, 20);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_start", 32'(o_start), 0);
    check("abort_humidity", 32'(humidity), 0);
    check("abort_temperature", 32'(current_temperature), 0);
    check("abort_data_valid", 32'(o_data_valid), 0);
    check("abort_busy", 32'(o_busy), 0);
    reset = 1'b0;
    t_prev = cyc;
    i_done = 1'b1; i_valid = 1'b1; i_humidity = 8'd77; i_temperature = 8'd77;
    @(negedge clk);
    i_done = 1'b0; i_valid = 1'b0;
    @(negedge clk);
    check("late_done_humidity", 32'(humidity), 0);
    check("late_done_data_valid", 32'(o_data_valid), 0);
    wait_start(1'b0, 40, t);
    check_near("gap_after_reset", t - t_prev, 10);

    // Trigger handling on the long-period instance.
    @(negedge clk);
    reset = 1'b1;
    reset_b = 1'b0;
    t_prev = cyc;
    repeat (3) @(negedge clk);
    i_trigger_b = 1'b1;
    @(negedge clk);
    i_trigger_b = 1'b0;
    wait_start(1'b1, 50, t);
    check_near("b_powerup_gap", t - t_prev, 10);
    t_prev = t;
    @(negedge clk);
    @(negedge clk);
    i_done_b = 1'b1; i_valid_b = 1'b1; i_humidity_b = 8'd33; i_temperature_b = 8'd22;
    @(negedge clk);
    i_done_b = 1'b0; i_valid_b = 1'b0;
    @(negedge clk);
    check("b_humidity", 32'(humidity_b), 33);
    check("b_temperature", 32'(current_temperature_b), 22);
    check("b_data_valid", 32'(o_data_valid_b), 1);
    repeat (296) @(negedge clk);
    i_trigger_b = 1'b1;
    @(negedge clk);
    i_trigger_b = 1'b0;
    wait_start(1'b1, 1100, t);
    check_near("b_trigger_gap", t - t_prev, 1000);
    t_prev = t;
    @(negedge clk);
    i_trigger_b = 1'b1;
    @(negedge clk);
    i_trigger_b = 1'b0;
    i_done_b = 1'b1; i_valid_b = 1'b1;
    @(negedge clk);
    i_done_b = 1'b0; i_valid_b = 1'b0;
    wait_start(1'b1, 2100, t);
    check_near("b_busy_trigger_ignored_gap", t - t_prev, 2000);

    check("queue_drained", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
